// File: rtl/arb_mux_pipe.sv
// Channel mux with one-word registered output stage.
// Grant comes from an external select (MODE=0) or round-robin arbitration (MODE=1).
module arb_mux_pipe #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 32,
    parameter int MODE     = 0,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] gnt_idx;
    logic gnt_vld;
    logic slot_open;
    logic xfer;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (MODE == 0) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!gnt_vld && sel == SEL_W'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            // Scan starts at ptr and wraps, so the lowest rotated index wins
            for (int k = 0; k < CHANNELS; k++) begin
                int idx;
                idx = (int'(ptr_q) + k) % CHANNELS;
                if (!gnt_vld && in_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(idx);
                end
            end
        end
    end

    // Gated by reset_n so nothing is offered while reset is held
    assign slot_open = (state_q == EMPTY) || out_ready;
    assign xfer      = gnt_vld && slot_open && reset_n;

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = FULL;
            data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            chan_d  = gnt_idx;
            if (gnt_idx == SEL_W'(CHANNELS - 1)) ptr_d = '0;
            else ptr_d = gnt_idx + 1'b1;
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_chan  = chan_q;

endmodule

// File: doc/arb_mux_pipe.md
ARB_MUX_PIPE -- requirements
Module: arb_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 32, bit width of every data channel.
REQ-002 Parameter CHANNELS, default 32, number of input channels, legal range 2..32.
REQ-003 Parameter MODE, default 0: 0 = externally selected channel, 1 = round-robin arbitration.
REQ-004 Derived SEL_W = ceil(log2(CHANNELS)), min 1.
REQ-005 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-006 clock  input  1  sole clock, all state updates on rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 in_data  input  CHANNELS*WIDTH  packed inputs, channel i at bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  CHANNELS  per-channel request/valid.
REQ-010 in_ready  output  CHANNELS  per-channel accept, one-hot or zero.
REQ-011 sel  input  SEL_W  requested channel, used only when MODE=0.
REQ-012 out_data  output  WIDTH  registered selected word.
REQ-013 out_valid  output  1  out_data/out_chan hold a word.
REQ-014 out_ready  input  1  downstream accepts the word.
REQ-015 out_chan  output  SEL_W  source channel of out_data.

Function
REQ-016 Input transfer on channel i SHALL occur on a rising edge where in_valid[i] and in_ready[i] are both 1; output transfer where out_valid and out_ready are both 1.
REQ-017 Block SHALL hold one output word; states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 Load slot open SHALL be: state EMPTY, or state FULL with out_ready=1 in the same cycle.
REQ-019 in_ready SHALL be combinational: at most one bit set, only for the granted channel, only when the load slot is open.
REQ-020 MODE=0 grant: channel sel if sel < CHANNELS and in_valid[sel]=1; otherwise no grant.
REQ-021 MODE=1 grant: lowest index j scanning ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1 with in_valid[j]=1; none if all in_valid=0.
REQ-022 Round-robin pointer ptr SHALL update to (granted index + 1) mod CHANNELS on every input transfer, unchanged otherwise; wrap from CHANNELS-1 to 0.
REQ-023 On input transfer, out_data/out_chan SHALL load the granted word/index next edge and out_valid SHALL become 1 (latency 1 cycle).
REQ-024 Output transfer with no simultaneous grant SHALL set out_valid=0 next edge; simultaneous output and input transfer SHALL keep out_valid=1 with the new word (full throughput, 1 word/cycle).
REQ-025 While FULL and out_ready=0, out_data, out_chan, out_valid SHALL remain stable and all in_ready SHALL be 0.
REQ-026 When out_valid=0, out_data and out_chan SHALL retain their last value.
REQ-027 in_valid SHALL not need to be held by the block's logic; withdrawn requests are simply not granted.
REQ-028 Changing sel (MODE=0) SHALL affect only the current-cycle grant; no sel state is stored.

Reset
REQ-029 reset_n=0 SHALL asynchronously force out_valid=0, out_data=0, out_chan=0, ptr=0, in_ready=0.
REQ-030 Reset asserted while FULL SHALL discard the held word; no transfer completes in a reset cycle.
REQ-031 First grant after reset_n deasserts SHALL occur no earlier than the first rising edge with reset_n=1.

Verification
REQ-032 MODE=0, CHANNELS=32: sel=5, in_valid[5]=1, channel 5 = 0xDEADBEEF, out_ready=1 -> in_ready=0x00000020, next cycle out_valid=1, out_data=0xDEADBEEF, out_chan=5.
REQ-033 MODE=0: sel=31 with in_valid[31]=0 -> in_ready=0, out_valid stays 0; CHANNELS=24, sel=27 -> no grant.
REQ-034 MODE=1, CHANNELS=4, all in_valid=1, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1, out_valid high every cycle after first.
REQ-035 MODE=1: word from channel 2 held, out_ready=0 for 3 cycles -> out_data/out_chan unchanged, in_ready=0 throughout; out_ready=1 with in_valid[3]=1 -> next word from channel 3, no bubble.
REQ-036 FULL with word 0x12345678, reset_n pulsed low mid-cycle -> out_valid=0, out_data=0, out_chan=0 immediately; after release, MODE=1 grants channel 0 first when all valid.
REQ-037 MODE=1, CHANNELS=3, ptr=2, in_valid=3'b011 -> grant channel 0 (wrap), then ptr=1.
